// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: EX-to-MEM pipeline inputs, MEM results and the data-memory req/ack bus.
interface mem_access_stage_if;
    logic        in_valid;
    logic [31:0] Ins;
    logic [31:0] Result;
    logic [31:0] Rdata2;
    logic        Stall;
    logic        out_valid;
    logic [31:0] WBdata;
    logic        AdErr;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        input  in_valid, Ins, Result, Rdata2, dmem_rdata, dmem_ack,
        output Stall, out_valid, WBdata, AdErr,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
    );

    modport slave (
        output in_valid, Ins, Result, Rdata2, dmem_rdata, dmem_ack,
        input  Stall, out_valid, WBdata, AdErr,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage running loads/stores over a req/ack bus with misalignment and timeout errors.
module mem_access_stage #(
    parameter int TIMEOUT = 64
) (
    input logic CLK,
    input logic RST,
    mem_access_stage_if.master bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
    localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t          state;
    logic [5:0]      op, op_q;
    logic [1:0]      off_q;
    logic [31:0]     rdata_q, load_val, wdata_c;
    logic [15:0]     lane;
    logic [3:0]      be_c;
    logic [CW-1:0]   cnt;
    logic            to_q, is_mem, is_word, is_half, misal;
    logic            unused_ins;

    assign op         = bus.Ins[31:26];
    assign unused_ins = ^bus.Ins[25:0];
    assign is_mem     = op inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
    assign is_word    = op == LW || op == SW;
    assign is_half    = op == LH || op == LHU || op == SH;
    assign misal      = is_word ? bus.Result[1:0] != 2'b00 : is_half && bus.Result[0];
    assign be_c       = is_word ? 4'b1111 : is_half ? 4'b0011 << bus.Result[1:0] : 4'b0001 << bus.Result[1:0];
    assign wdata_c    = op == SB ? {4{bus.Rdata2[7:0]}} : op == SH ? {2{bus.Rdata2[15:0]}} : op == SW ? bus.Rdata2 : '0;

    // Extraction works off the captured word so DONE has a full cycle to shift and extend.
    assign lane       = 16'(rdata_q >> {off_q, 3'b000});
    assign load_val   = op_q == LB  ? {{24{lane[7]}}, lane[7:0]} :
                        op_q == LBU ? {24'd0, lane[7:0]} :
                        op_q == LH  ? {{16{lane[15]}}, lane} :
                        op_q == LHU ? {16'd0, lane} :
                        op_q == LW  ? rdata_q : '0;

    assign bus.Stall  = state != IDLE;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state          <= IDLE;
            op_q           <= '0;
            off_q          <= '0;
            rdata_q        <= '0;
            cnt            <= '0;
            to_q           <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.WBdata     <= '0;
            bus.AdErr      <= 1'b0;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_be    <= '0;
            bus.dmem_wdata <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.AdErr     <= 1'b0;
            case (state)
                IDLE: if (bus.in_valid) begin
                    if (!is_mem || misal) begin
                        bus.WBdata    <= bus.Result;
                        bus.out_valid <= 1'b1;
                        bus.AdErr     <= is_mem;
                    end else begin
                        op_q           <= op;
                        off_q          <= bus.Result[1:0];
                        cnt            <= '0;
                        bus.dmem_req   <= 1'b1;
                        bus.dmem_we    <= op inside {SB, SH, SW};
                        bus.dmem_addr  <= {bus.Result[31:2], 2'b00};
                        bus.dmem_be    <= be_c;
                        bus.dmem_wdata <= wdata_c;
                        state          <= BUS;
                    end
                end
                BUS: if (bus.dmem_ack) begin
                    rdata_q      <= bus.dmem_rdata;
                    to_q         <= 1'b0;
                    bus.dmem_req <= 1'b0;
                    state        <= DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    to_q         <= 1'b1;
                    bus.dmem_req <= 1'b0;
                    state        <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    bus.out_valid <= 1'b1;
                    bus.AdErr     <= to_q;
                    bus.WBdata    <= to_q ? '0 : load_val;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized and directed checks of the MEM stage against a transaction-level model.
module tb_mem_access_stage;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    mem_access_stage_if bus ();

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .CLK(clk),
        .RST(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int op_size(input logic [5:0] op);
        case (op)
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            6'h23, 6'h2B:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [5:0] op);
        return op == 6'h28 || op == 6'h29 || op == 6'h2B;
    endfunction

    function automatic logic [3:0] model_be(input logic [5:0] op, input int off);
        logic [3:0] be;
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + op_size(op));
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] rd2);
        logic [31:0] w;
        int sz;
        sz = op_size(op);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rd2[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_wb(input logic [5:0] op, input int off, input logic [31:0] rd);
        logic [31:0] lane;
        lane = rd >> (8 * off);
        case (op)
            6'h20:   return 32'($signed(lane[7:0]));
            6'h24:   return lane & 32'hFF;
            6'h21:   return 32'($signed(lane[15:0]));
            6'h25:   return lane & 32'hFFFF;
            6'h23:   return rd;
            default: return 32'h0;
        endcase
    endfunction

    task automatic run(input logic [5:0] op, input logic [31:0] res, input logic [31:0] rd2,
                       input logic [31:0] rdata, input int ack_k);
        int sz, off, cyc, exp_cyc;
        sz  = op_size(op);
        off = int'(res[1:0]);
        cyc = 0;
        bus.in_valid = 1'b1;
        bus.Ins      = {op, 26'($urandom)};
        bus.Result   = res;
        bus.Rdata2   = rd2;
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (sz == 0 || off % sz != 0) begin
            check("imm_valid", bus.out_valid, 1);
            check("imm_aderr", bus.AdErr, 32'(sz != 0));
            check("imm_wb", bus.WBdata, res);
            check("imm_stall", bus.Stall, 0);
            check("imm_req", bus.dmem_req, 0);
            return;
        end
        check("bus_req", bus.dmem_req, 1);
        check("bus_stall", bus.Stall, 1);
        check("bus_addr", bus.dmem_addr, res & ~32'h3);
        check("bus_we", bus.dmem_we, 32'(op_store(op)));
        if (op_store(op)) check("bus_wdata", bus.dmem_wdata, model_wdata(op, rd2));
        while (bus.dmem_req && cyc < 3 * TO) begin
            cyc++;
            check("bus_be", bus.dmem_be, model_be(op, off));
            check("bus_stall_hold", bus.Stall, 1);
            if (cyc == ack_k) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = rdata;
            end else begin
                bus.dmem_rdata = $urandom;
                bus.in_valid   = 1'($urandom_range(0, 1));
                bus.Ins        = {6'h00, 26'($urandom)};
            end
            @(negedge clk);
            bus.dmem_ack = 1'b0;
            bus.in_valid = 1'b0;
        end
        exp_cyc = ack_k <= TO ? ack_k : TO;
        check("req_cycles", 32'(cyc), 32'(exp_cyc));
        check("done_valid", bus.out_valid, 0);
        check("done_stall", bus.Stall, 1);
        @(negedge clk);
        check("res_valid", bus.out_valid, 1);
        check("res_stall", bus.Stall, 0);
        check("res_aderr", bus.AdErr, 32'(ack_k > TO));
        check("res_wb", bus.WBdata, ack_k > TO ? 32'h0 : model_wb(op, off, rdata));
    endtask

    logic [5:0] ops [11] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h09, 6'h0F};

    initial begin
        bus.in_valid   = 1'b0;
        bus.Ins        = '0;
        bus.Result     = '0;
        bus.Rdata2     = '0;
        bus.dmem_rdata = '0;
        bus.dmem_ack   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", bus.dmem_req, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_stall", bus.Stall, 0);
        check("rst_wb", bus.WBdata, 0);
        check("rst_aderr", bus.AdErr, 0);
        check("rst_be", bus.dmem_be, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(6'h23, 32'h100, 32'h0, 32'hDEADBEEF, 3);
        run(6'h20, 32'h103, 32'h0, 32'h80FF_1234, 2);
        run(6'h24, 32'h103, 32'h0, 32'h80FF_1234, 1);
        run(6'h29, 32'h202, 32'h0000_ABCD, 32'h1111_1111, 2);
        run(6'h23, 32'h101, 32'h0, 32'h0, 1);
        run(6'h00, 32'h7, 32'h0, 32'h0, 1);
        run(6'h2B, 32'h300, 32'h1234_5678, 32'h0, 99);
        run(6'h23, 32'h104, 32'h0, 32'hCAFE_F00D, TO);

        // Abort a transaction with reset while the request is outstanding.
        bus.in_valid = 1'b1;
        bus.Ins      = {6'h23, 26'd0};
        bus.Result   = 32'h400;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("rstbus_req_pre", bus.dmem_req, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstbus_req", bus.dmem_req, 0);
        check("rstbus_stall", bus.Stall, 0);
        check("rstbus_valid", bus.out_valid, 0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstbus_after_valid", bus.out_valid, 0);
            check("rstbus_after_req", bus.dmem_req, 0);
            check("rstbus_after_stall", bus.Stall, 0);
            @(negedge clk);
        end

        for (int n = 0; n < 60; n++) begin
            logic [5:0]  op;
            logic [31:0] res;
            int sz;
            op  = ops[$urandom_range(0, 10)];
            sz  = op_size(op);
            res = $urandom;
            if ($urandom_range(0, 2) != 0 && sz > 1) res = res & ~32'(sz - 1);
            run(op, res, $urandom, $urandom, $urandom_range(1, TO + 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
